// File: rtl/vga_pixel_prefetch.sv
// ---------------------------------------------------------------------------
// vga_pixel_prefetch
//
// Streams a grayscale image (one byte per pixel) out of data memory through a
// single-outstanding request/grant/rvalid read port, expands every byte to a
// 24-bit {g,g,g} pixel and buffers it in a small FIFO. The downstream VGA
// sync/colour stage pops one pixel per active-window clock, so display timing
// does not depend on memory latency.
//
// Ports
//   VGA_CLK_IN   in   1       pixel clock, all state changes on rising edge
//   rst          in   1       asynchronous active-high reset
//   frame_start  in   1       one-cycle pulse, restarts the image from pixel 0
//   pop          in   1       consumer takes the head pixel this cycle
//   px           out  24      head pixel {g,g,g}
//   px_valid     out  1       FIFO not empty
//   underflow    out  1       sticky, set by a pop while the FIFO is empty
//   mem_req      out  1       read request (held until mem_gnt)
//   mem_addr     out  ADDR_W  byte address of the read
//   mem_gnt      in   1       request accepted this cycle
//   mem_rvalid   in   1       read data valid, one or more cycles after mem_gnt
//   mem_rdata    in   8       grayscale byte
// ---------------------------------------------------------------------------
module vga_pixel_prefetch #(
  parameter int unsigned BASE_ADDR  = 24,
  parameter int unsigned NUM_PIXELS = 90000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              VGA_CLK_IN,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pop,
  output logic [23:0]       px,
  output logic              px_valid,
  output logic              underflow,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FET_W = $clog2(NUM_PIXELS + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [FET_W-1:0]  NUM_C   = FET_W'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [FET_W-1:0]    fetched_q, fetched_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]          px_q, px_d;
  logic                underflow_q, underflow_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  // Pixel storage: plain array without reset so it maps onto RAM.
  logic [7:0]          fifo_mem [FIFO_DEPTH];

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  logic             grant;
  logic             push;
  logic             pop_ok;
  logic             not_empty;
  logic [PTR_W-1:0] rd_next;

  assign not_empty = (count_q != '0);
  // A grant only counts while a request is actually on the bus.
  assign grant     = (state_q == FETCH) && mem_req_q && mem_gnt;
  // frame_start discards any data returning in the same cycle.
  assign push      = (state_q == WAIT) && mem_rvalid && !frame_start;
  // frame_start wins over pop: a flushed FIFO is never popped.
  assign pop_ok    = pop && not_empty && !frame_start;
  assign rd_next   = rd_ptr_q + PTR_W'(1);

  // -------------------------------------------------------------------------
  // Fetch FSM: next state and pixel counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    fetched_d = fetched_q;

    case (state_q)
      FETCH: begin
        if (grant) begin
          fetched_d = fetched_q + FET_W'(1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = (fetched_q == NUM_C) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      DRAIN: begin
        if (mem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (frame_start) begin
      fetched_d = '0;
      case (state_q)
        // A read is still in flight unless its data returns right now;
        // an in-flight read must be drained before the next request so
        // that only one read is ever outstanding.
        WAIT:    state_d = mem_rvalid ? FETCH : DRAIN;
        DRAIN:   state_d = mem_rvalid ? FETCH : DRAIN;
        // A grant coinciding with the restart also leaves a read in flight.
        FETCH:   state_d = grant ? DRAIN : FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO bookkeeping and head register
  // -------------------------------------------------------------------------
  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    px_d        = px_q;
    underflow_d = underflow_q;

    if (frame_start) begin
      // Flush; px keeps its last value.
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      underflow_d = 1'b0;
    end else begin
      if (pop && !not_empty) begin
        underflow_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_next;
      end

      case ({push, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Head register: after a pop it loads the next stored entry, or the
      // byte being pushed when that byte becomes the only entry. A push into
      // an empty FIFO (also during an underflowing pop) loads it directly.
      // Popping the last entry without a push leaves px unchanged.
      if (pop_ok) begin
        if (count_q > CNT_W'(1)) begin
          px_d = fifo_mem[rd_next];
        end else if (push) begin
          px_d = mem_rdata;
        end
      end else if (!not_empty && push) begin
        px_d = mem_rdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request generation
  // -------------------------------------------------------------------------
  // The request is registered and computed from next-state values. Only one
  // read can be outstanding and a request needs a free slot, so a push can
  // never overflow. While waiting for a grant, count can only fall and
  // fetched cannot move, so the request and address hold by construction.
  // frame_start forces one idle cycle before the restarted request.
  assign mem_req_d  = !frame_start &&
                      (state_d == FETCH) &&
                      (count_d < DEPTH_C) &&
                      (fetched_d < NUM_C);
  assign mem_addr_d = BASE_C + ADDR_W'(fetched_d);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge VGA_CLK_IN or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      fetched_q   <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      px_q        <= 8'h00;
      underflow_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= BASE_C;
    end else begin
      state_q     <= state_d;
      fetched_q   <= fetched_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      px_q        <= px_d;
      underflow_q <= underflow_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  always_ff @(posedge VGA_CLK_IN) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign px        = {3{px_q}};
  assign px_valid  = not_empty;
  assign underflow = underflow_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
`timescale 1ns/1ps
module tb_vga_pixel_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        frame_start_s [2];
  logic        pop_s         [2];
  logic        mem_gnt_s     [2];
  logic        mem_rvalid_s  [2];
  logic [7:0]  mem_rdata_s   [2];
  logic [23:0] px_s          [2];
  logic        px_valid_s    [2];
  logic        underflow_s   [2];
  logic        mem_req_s     [2];
  logic [31:0] mem_addr_s    [2];

  // Instance 0: full-size frame. Instance 1: 20-pixel frame for end-of-frame.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    vga_pixel_prefetch #(
      .BASE_ADDR (24),
      .NUM_PIXELS((gi == 0) ? 90000 : 20),
      .FIFO_DEPTH(16),
      .ADDR_W    (32)
    ) u_dut (
      .VGA_CLK_IN (clk),
      .rst        (rst),
      .frame_start(frame_start_s[gi]),
      .pop        (pop_s[gi]),
      .px         (px_s[gi]),
      .px_valid   (px_valid_s[gi]),
      .underflow  (underflow_s[gi]),
      .mem_req    (mem_req_s[gi]),
      .mem_addr   (mem_addr_s[gi]),
      .mem_gnt    (mem_gnt_s[gi]),
      .mem_rvalid (mem_rvalid_s[gi]),
      .mem_rdata  (mem_rdata_s[gi])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: byte at address a.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] t;
    t = (a * 32'd37) ^ 32'h5A;
    return t[7:0];
  endfunction

  function automatic int dut_count();
    if (sel == 0) return int'(g_dut[0].u_dut.count_q);
    return int'(g_dut[1].u_dut.count_q);
  endfunction

  function automatic int dut_state();
    if (sel == 0) return int'(g_dut[0].u_dut.state_q);
    return int'(g_dut[1].u_dut.state_q);
  endfunction

  // -------------------------------------------------------------------------
  // Memory responder (acts on the selected instance, #2 after each edge)
  // -------------------------------------------------------------------------
  int          lat_min    = 1;
  int          lat_max    = 1;
  int          stall_req  = 0;
  int          gnt_budget = -1;
  int          pend       = 0;
  logic [31:0] pend_addr  = '0;
  logic [31:0] gnt_log [$];
  logic [23:0] exp_q   [$];

  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      mem_gnt_s[i]    = 1'b0;
      mem_rvalid_s[i] = 1'b0;
    end
    if (rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid_s[sel] = 1'b1;
          mem_rdata_s[sel]  = mem_byte(pend_addr);
        end
      end
      if (mem_req_s[sel] && pend == 0) begin
        if (stall_req > 0) begin
          stall_req--;
        end else if (gnt_budget != 0) begin
          if (gnt_budget > 0) gnt_budget--;
          mem_gnt_s[sel] = 1'b1;
          pend      = int'($urandom_range(lat_max, lat_min));
          pend_addr = mem_addr_s[sel];
          gnt_log.push_back(pend_addr);
          // A grant in the restart cycle is drained, never displayed.
          if (!frame_start_s[sel]) exp_q.push_back({3{mem_byte(pend_addr)}});
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard monitor: every accepted pop is compared with the queue head
  // -------------------------------------------------------------------------
  int n_popped = 0;
  always @(negedge clk) begin : mon
    logic [23:0] e_px;
    if (!rst && pop_s[sel] && px_valid_s[sel] && !frame_start_s[sel]) begin
      n_popped++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_px: pop with no expected pixel, got %h (t=%0t)", px_s[sel], $time);
      end else begin
        e_px = exp_q.pop_front();
        check("sb_px", px_s[sel], e_px);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   mem_req_s[sel],   0);
    check({tag, "_mem_addr"},  mem_addr_s[sel],  24);
    check({tag, "_px"},        px_s[sel],        0);
    check({tag, "_px_valid"},  px_valid_s[sel],  0);
    check({tag, "_underflow"}, underflow_s[sel], 0);
    check({tag, "_count"},     dut_count(),      0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pop_s[i]         = 1'b0;
      frame_start_s[i] = 1'b0;
    end
    exp_q.delete();
    gnt_log.delete();
    tick();
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
  endtask

  int base_pops;
  int npop;

  initial begin
    sel = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frame_start_s[i] = 1'b0;
      pop_s[i]         = 1'b0;
      mem_gnt_s[i]     = 1'b0;
      mem_rvalid_s[i]  = 1'b0;
      mem_rdata_s[i]   = 8'h00;
    end

    // ---- Reset then free-run: 16 requests, FIFO full, head = byte 24 ----
    lat_min = 1; lat_max = 1;
    do_reset();
    tick();
    check("first_req", mem_req_s[0], 1);
    check("first_addr", mem_addr_s[0], 24);
    repeat (45) tick();
    check("fill_ngnt", gnt_log.size(), 16);
    for (int i = 0; i < 16 && i < gnt_log.size(); i++)
      check("fill_addr", gnt_log[i], 32'(24 + i));
    check("fill_req_idle", mem_req_s[0], 0);
    check("fill_count", dut_count(), 16);
    check("fill_px_valid", px_valid_s[0], 1);
    check("fill_px", px_s[0], 24'h222222);

    // ---- Steady stream: pop every 3rd cycle, latency 1..2 ----
    lat_min = 1; lat_max = 2;
    base_pops = n_popped;
    for (int k = 0; k < 600; k++) begin
      pop_s[0] = (k % 3 == 0);
      tick();
    end
    pop_s[0] = 1'b0;
    check("steady_pops", n_popped - base_pops, 200);
    check("steady_underflow", underflow_s[0], 0);

    // ---- Stalled grant: 5 cycles without grant, then exactly one push ----
    lat_min = 1; lat_max = 1;
    stall_req = 5; gnt_budget = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_req", mem_req_s[0], 1);
      check("stall_addr", mem_addr_s[0], 24);
    end
    tick();
    tick();
    check("stall_count", dut_count(), 1);
    check("stall_px", px_s[0], 24'h222222);
    check("stall_next_addr", mem_addr_s[0], 25);
    repeat (4) tick();
    check("stall_one_push", dut_count(), 1);
    check("stall_ngnt", gnt_log.size(), 1);
    stall_req = 0; gnt_budget = -1;

    // ---- Mid-fetch restart: frame_start in WAIT, rvalid 3 cycles late ----
    lat_min = 3; lat_max = 3;
    do_reset();
    tick();
    pop_s[0] = 1'b1;               // pop on an empty FIFO
    tick();
    pop_s[0] = 1'b0;
    check("mid_underflow_set", underflow_s[0], 1);
    check("mid_in_wait", dut_state(), 1);
    frame_start_s[0] = 1'b1;
    exp_q.delete();
    gnt_log.delete();
    tick();
    frame_start_s[0] = 1'b0;
    check("mid_flush_valid", px_valid_s[0], 0);
    check("mid_flush_underflow", underflow_s[0], 0);
    check("mid_drain", dut_state(), 3);
    check("mid_req_drop", mem_req_s[0], 0);
    tick();
    check("mid_still_drain", dut_state(), 3);
    tick();
    check("mid_refetch", dut_state(), 0);
    check("mid_stale_dropped", px_valid_s[0], 0);
    check("mid_req", mem_req_s[0], 1);
    check("mid_addr", mem_addr_s[0], 24);
    pop_s[0] = 1'b1;               // underflowing pop: count unchanged
    tick();
    pop_s[0] = 1'b0;
    check("mid_underflow_again", underflow_s[0], 1);
    check("mid_count_kept", dut_count(), 0);
    for (int c = 0; c < 20 && !px_valid_s[0]; c++) tick();
    check("mid_valid_timeout", px_valid_s[0], 1);
    check("mid_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : 32'hFFFFFFFF, 24);
    check("mid_first_count", dut_count(), 1);
    check("mid_first_px", px_s[0], 24'h222222);
    pop_s[0] = 1'b1;
    tick();
    pop_s[0] = 1'b0;

    // ---- Asynchronous reset between clock edges ----
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 20 && !mem_req_s[0]; c++) tick();
    check("async_pre_req", mem_req_s[0], 1);
    check("async_pre_underflow", underflow_s[0], 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    gnt_log.delete();
    #1;
    check_reset_outputs("async");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("async_restart_req", mem_req_s[0], 1);
    check("async_restart_addr", mem_addr_s[0], 24);

    // ---- End of frame on the 20-pixel instance ----
    sel = 1;
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (40) tick();
    npop = 0;
    for (int c = 0; c < 200 && npop < 20; c++) begin
      pop_s[1] = px_valid_s[1];
      if (px_valid_s[1]) npop++;
      tick();
    end
    pop_s[1] = 1'b0;
    repeat (3) tick();
    check("eof_pops", npop, 20);
    check("eof_ngnt", gnt_log.size(), 20);
    check("eof_last_addr", (gnt_log.size() > 0) ? gnt_log[gnt_log.size()-1] : 32'hFFFFFFFF, 43);
    check("eof_done", dut_state(), 2);
    check("eof_req_idle", mem_req_s[1], 0);
    check("eof_empty", px_valid_s[1], 0);
    pop_s[1] = 1'b1;               // 21st pop
    tick();
    pop_s[1] = 1'b0;
    check("eof_underflow", underflow_s[1], 1);
    check("eof_px_hold", px_s[1], 24'h6D6D6D);
    check("eof_count", dut_count(), 0);
    check("eof_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "time limit");
  end

endmodule
